// File: rtl/te_pkg.sv
// te_pkg: state encoding and default parameters shared by radio_timing_engine.
// FAULT is only part of the encoding when TE_PLL_TIMEOUT_EN is defined.
package te_pkg;
    localparam int TE_NUM_CH      = 2;
    localparam int TE_CNT_WIDTH   = 8;
    localparam int TE_TIMEOUT_CYC = 1000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PLL,
        ARST,
        ACTIVE
`ifdef TE_PLL_TIMEOUT_EN
        , FAULT
`endif
    } te_state_t;
endpackage

// File: rtl/te_channel_fsm.sv
// te_channel_fsm: per-channel enable sequencer (PLL wait, settle delay, two output stages).
// TE_PLL_TIMEOUT_EN adds a WAIT_PLL watchdog that parks the channel in FAULT.
module te_channel_fsm
    import te_pkg::*;
#(
    parameter int CNT_WIDTH = TE_CNT_WIDTH
`ifdef TE_PLL_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = TE_TIMEOUT_CYC
`endif
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 en,
    input  logic                 rx,
    input  logic                 pll,
    input  logic [CNT_WIDTH-1:0] t_arst,
    output logic                 enable1,
    output logic                 rx_en1,
    output logic                 enable2,
    output logic                 rx_en2,
    output logic                 pll_timeout,
    output logic                 busy
);
    te_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 en1_q, en1_d, rx1_q, rx1_d, en2_q, en2_d, rx2_q, rx2_d;
`ifdef TE_PLL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef TE_PLL_TIMEOUT_EN
        wd_d    = '0;
`endif
        case (state_q)
            IDLE: state_d = WAIT_PLL;
            WAIT_PLL: begin
                if (pll) begin
                    state_d = (t_arst == '0) ? ACTIVE : ARST;
                    cnt_d   = t_arst;
                end
`ifdef TE_PLL_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) state_d = FAULT;
                else wd_d = wd_q + 1'b1;
`endif
            end
            ARST: begin
                if (!pll) state_d = WAIT_PLL;
                else if (cnt_q == CNT_WIDTH'(1)) state_d = ACTIVE;
                else cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
        // Dropping the request wins over lock, count expiry and fault alike.
        if (!en) state_d = IDLE;
        en1_d = (state_d == ACTIVE);
        rx1_d = en1_d & rx;
        en2_d = en1_q;
        rx2_d = rx1_q;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en1_q   <= 1'b0;
            rx1_q   <= 1'b0;
            en2_q   <= 1'b0;
            rx2_q   <= 1'b0;
`ifdef TE_PLL_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en1_q   <= en1_d;
            rx1_q   <= rx1_d;
            en2_q   <= en2_d;
            rx2_q   <= rx2_d;
`ifdef TE_PLL_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    assign enable1 = en1_q;
    assign rx_en1  = rx1_q;
    assign enable2 = en2_q;
    assign rx_en2  = rx2_q;
    assign busy    = (state_q != IDLE);
`ifdef TE_PLL_TIMEOUT_EN
    assign pll_timeout = (state_q == FAULT);
`else
    assign pll_timeout = 1'b0;
`endif
endmodule

// File: rtl/radio_timing_engine.sv
// radio_timing_engine: request synchronisers plus one te_channel_fsm per radio channel.
// Define TE_PLL_TIMEOUT_EN to enable the per-channel PLL-wait watchdog.
module radio_timing_engine
    import te_pkg::*;
#(
    parameter int NUM_CH      = TE_NUM_CH,
    parameter int CNT_WIDTH   = TE_CNT_WIDTH,
    parameter int TIMEOUT_CYC = TE_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic [NUM_CH-1:0]    radioEnableUnsynced,
    input  logic [NUM_CH-1:0]    radioRxEnUnsynced,
    input  logic [NUM_CH-1:0]    pllSettled,
    input  logic [CNT_WIDTH-1:0] tArstFs,
    output logic [NUM_CH-1:0]    radioEnableSynced,
    output logic [NUM_CH-1:0]    radioRxEnSynced,
    output logic [NUM_CH-1:0]    radioEnable1,
    output logic [NUM_CH-1:0]    radioRxEn1,
    output logic [NUM_CH-1:0]    radioEnable2,
    output logic [NUM_CH-1:0]    radioRxEn2,
    output logic [NUM_CH-1:0]    pllTimeout,
    output logic                 busy
);
    logic [NUM_CH-1:0] en_s1_q, en_s1_d, en_s2_q, en_s2_d;
    logic [NUM_CH-1:0] rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [NUM_CH-1:0] busy_ch;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    always_comb begin
        en_s1_d = radioEnableUnsynced;
        en_s2_d = en_s1_q;
        rx_s1_d = radioRxEnUnsynced;
        rx_s2_d = rx_s1_q;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            en_s1_q <= '0;
            en_s2_q <= '0;
            rx_s1_q <= '0;
            rx_s2_q <= '0;
        end else begin
            en_s1_q <= en_s1_d;
            en_s2_q <= en_s2_d;
            rx_s1_q <= rx_s1_d;
            rx_s2_q <= rx_s2_d;
        end
    end

    assign radioEnableSynced = en_s2_q;
    assign radioRxEnSynced   = rx_s2_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        te_channel_fsm #(
            .CNT_WIDTH   (CNT_WIDTH)
`ifdef TE_PLL_TIMEOUT_EN
            , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
        ) u_ch (
            .clk         (clk),
            .nReset      (nReset),
            .en          (en_s2_q[i]),
            .rx          (rx_s2_q[i]),
            .pll         (pllSettled[i]),
            .t_arst      (tArstFs),
            .enable1     (radioEnable1[i]),
            .rx_en1      (radioRxEn1[i]),
            .enable2     (radioEnable2[i]),
            .rx_en2      (radioRxEn2[i]),
            .pll_timeout (pllTimeout[i]),
            .busy        (busy_ch[i])
        );
    end

    assign busy = |busy_ch;
endmodule

// File: tb/tb_radio_timing_engine.sv
// tb_radio_timing_engine: directed and random stimulus against a behavioural channel model.
// Honours TE_PLL_TIMEOUT_EN for the watchdog scenario.
module tb_radio_timing_engine;
    localparam int NUM_CH      = 2;
    localparam int CNT_WIDTH   = 8;
    localparam int TIMEOUT_CYC = 20;
    localparam int M_IDLE = 0, M_WAIT = 1, M_SETTLE = 2, M_ACTIVE = 3, M_FAULT = 4;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic [NUM_CH-1:0] en_u = '0, rx_u = '0, pll = '0;
    logic [CNT_WIDTH-1:0] t_arst = '0;
    logic [NUM_CH-1:0] en_s, rx_s, en1, rx1, en2, rx2, pto;
    logic busy;
    int checks = 0;
    int errors = 0;

    int mode [NUM_CH];
    int left [NUM_CH];
    int waited [NUM_CH];
    logic [NUM_CH-1:0] m_s1, m_s2, m_rs1, m_rs2, m_en1, m_rx1, m_en2, m_rx2;

    always #5 clk = ~clk;

    radio_timing_engine #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .nReset(nReset),
        .radioEnableUnsynced(en_u), .radioRxEnUnsynced(rx_u),
        .pllSettled(pll), .tArstFs(t_arst),
        .radioEnableSynced(en_s), .radioRxEnSynced(rx_s),
        .radioEnable1(en1), .radioRxEn1(rx1),
        .radioEnable2(en2), .radioRxEn2(rx2),
        .pllTimeout(pto), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mode[c] = M_IDLE;
            left[c] = 0;
            waited[c] = 0;
        end
        {m_s1, m_s2, m_rs1, m_rs2, m_en1, m_rx1, m_en2, m_rx2} = '0;
    endtask

    // One clock of the specified behaviour, using the inputs the DUT sampled.
    task automatic model_step();
        logic [NUM_CH-1:0] a, r;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!m_s2[c]) mode[c] = M_IDLE;
            else if (mode[c] == M_IDLE) begin
                mode[c] = M_WAIT;
                waited[c] = 0;
            end else if (mode[c] == M_WAIT) begin
                if (pll[c]) begin
                    left[c] = int'(t_arst);
                    mode[c] = (left[c] == 0) ? M_ACTIVE : M_SETTLE;
                end else begin
                    waited[c]++;
`ifdef TE_PLL_TIMEOUT_EN
                    if (waited[c] == TIMEOUT_CYC) mode[c] = M_FAULT;
`endif
                end
            end else if (mode[c] == M_SETTLE) begin
                if (!pll[c]) begin
                    mode[c] = M_WAIT;
                    waited[c] = 0;
                end else begin
                    left[c]--;
                    if (left[c] == 0) mode[c] = M_ACTIVE;
                end
            end
            a[c] = (mode[c] == M_ACTIVE);
            r[c] = a[c] && m_rs2[c];
        end
        m_en2 = m_en1;
        m_rx2 = m_rx1;
        m_en1 = a;
        m_rx1 = r;
        m_s2 = m_s1;
        m_s1 = en_u;
        m_rs2 = m_rs1;
        m_rs1 = rx_u;
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] f;
        logic b;
        b = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            f[c] = (mode[c] == M_FAULT);
            b = b | (mode[c] != M_IDLE);
        end
        check("enable_synced", en_s, m_s2);
        check("rx_synced", rx_s, m_rs2);
        check("enable1", en1, m_en1);
        check("rx_en1", rx1, m_rx1);
        check("enable2", en2, m_en2);
        check("rx_en2", rx2, m_rx2);
        check("pll_timeout", pto, f);
        check("busy", busy, b);
    endtask

    always @(posedge clk) begin
        #1;
        if (!nReset) model_reset();
        else model_step();
        compare_all();
    end

    task automatic release_ch(input int ch);
        @(negedge clk);
        en_u[ch] = 1'b0;
        rx_u[ch] = 1'b0;
        pll[ch] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Edges from the load edge until enable1 rises; t2 replaces tArstFs mid-settle.
    task automatic settle_latency(input int ch, input int t, input int t2, input bit drop,
                                  output int n);
        @(negedge clk);
        t_arst = CNT_WIDTH'(t);
        pll[ch] = 1'b0;
        rx_u[ch] = 1'b1;
        en_u[ch] = 1'b1;
        repeat (5) @(negedge clk);
        pll[ch] = 1'b1;
        @(posedge clk);
        if (drop) begin
            @(negedge clk);
            pll[ch] = 1'b0;
            repeat (2) @(negedge clk);
            pll[ch] = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        t_arst = CNT_WIDTH'(t2);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #2;
            n = k;
            if (en1[ch]) break;
        end
    endtask

    initial begin
        int n;
        #1 model_reset();
        check("reset_enable1", en1, 0);
        check("reset_busy", busy, 0);
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_enable2", en2, 0);

        settle_latency(0, 3, 3, 1'b0, n);
        check("settle3_latency", n, 3);
        check("settle3_rx_en1", rx1[0], 1);
        @(posedge clk);
        #2 check("settle3_enable2", en2[0], 1);
        release_ch(0);

        settle_latency(0, 10, 2, 1'b0, n);
        check("settle_ignores_change", n, 10);
        release_ch(0);

        settle_latency(1, 4, 4, 1'b1, n);
        check("settle_after_relock", n, 4);
        release_ch(1);

        // Zero settle delay with lock already present.
        @(negedge clk);
        t_arst = '0;
        pll[1] = 1'b1;
        en_u[1] = 1'b1;
        repeat (3) @(posedge clk);
        #2 check("zero_delay_wait_cycle", en1[1], 0);
        @(posedge clk);
        #2 check("zero_delay_active", en1[1], 1);
        release_ch(1);

        // Request withdrawn mid-settle while locked.
        @(negedge clk);
        t_arst = 8'd20;
        en_u[0] = 1'b1;
        repeat (5) @(negedge clk);
        pll[0] = 1'b1;
        repeat (3) @(negedge clk);
        en_u[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 check("drop_still_busy", busy, 1);
        @(posedge clk);
        #2 check("drop_idle_busy", busy, 0);
        check("drop_enable1", en1[0], 0);
        release_ch(0);

        // Asynchronous reset while active.
        @(negedge clk);
        t_arst = 8'd1;
        rx_u[0] = 1'b1;
        en_u[0] = 1'b1;
        pll[0] = 1'b1;
        repeat (8) @(posedge clk);
        #2 check("pre_reset_active", en1[0], 1);
        @(negedge clk);
        #2 nReset = 1'b0;
        #1;
        check("async_enable1", en1, 0);
        check("async_enable2", en2, 0);
        check("async_synced", en_s, 0);
        check("async_busy", busy, 0);
        @(negedge clk);
        nReset = 1'b1;
        release_ch(0);

`ifdef TE_PLL_TIMEOUT_EN
        @(negedge clk);
        en_u[0] = 1'b1;
        pll[1] = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #2;
            n = k;
            if (pto[0]) break;
        end
        check("timeout_edge", n, 23);
        check("timeout_other_ch", pto[1], 0);
        check("timeout_enable1", en1[0], 0);
        @(negedge clk);
        en_u[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("timeout_cleared", pto[0], 0);
        release_ch(0);
`endif

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(99) < 4) en_u[c] = ~en_u[c];
                if ($urandom_range(99) < 6) rx_u[c] = ~rx_u[c];
                if ($urandom_range(99) < 12) pll[c] = ~pll[c];
            end
            if ($urandom_range(99) < 5) t_arst = CNT_WIDTH'($urandom_range(6));
            if ($urandom_range(999) < 3) begin
                #2 nReset = 1'b0;
                #1 check("random_async_busy", busy, 0);
                @(negedge clk);
                nReset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "time limit reached");
    end
endmodule
